// File: rtl/pong_pkg.sv
// Shared definitions for the Pong serial command path: sync marker, command
// codes, controller state encoding and header bit positions.
package pong_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [1:0] CMD_STOP  = 2'd0;
    localparam logic [1:0] CMD_UP    = 2'd1;
    localparam logic [1:0] CMD_DOWN  = 2'd2;
    localparam logic [1:0] CMD_SERVE = 2'd3;

    // Header byte layout: {player, 5'b0, code}
    localparam int unsigned HDR_PLAYER_BIT = 7;
    localparam int unsigned HDR_PAD_MSB    = 6;
    localparam int unsigned HDR_PAD_LSB    = 2;
    localparam int unsigned HDR_CODE_MSB   = 1;
    localparam int unsigned HDR_CODE_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ARG,
        ST_CHK,
        ST_HOLD
    } rx_state_t;

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear and
// flags expiry on the last allowed cycle.
module rx_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 2000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_count;

    // Holds at LAST so a missed expiry can never wrap back to a short count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/pong_rx_controller.sv
// Frames receiver bytes into 4-byte Pong command packets, checks header and
// checksum, enforces inter-byte timeout and hands commands to game logic.
module pong_rx_controller
    import pong_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2000,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic       bounderClock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       cmd_accept,
    input  logic       clear_err,
    output logic       cmd_valid,
    output logic       cmd_player,
    output logic [1:0] cmd_code,
    output logic [7:0] cmd_arg,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy,
    output logic [7:0] err_count
);

    rx_state_t r_state;
    rx_state_t w_next_state;

    logic [7:0] r_hdr;
    logic [7:0] r_arg;
    logic       r_cmd_valid;
    logic       r_cmd_player;
    logic [1:0] r_cmd_code;
    logic [7:0] r_cmd_arg;
    logic       r_frame_error;
    logic       r_overrun;
    logic       r_busy;
    logic [7:0] r_err_count;

    logic w_frame_error;
    logic w_overrun;
    logic w_load_hdr;
    logic w_load_arg;
    logic w_load_cmd;
    logic w_in_packet;
    logic w_expired;

    assign w_in_packet = (r_state == ST_HDR) || (r_state == ST_ARG) || (r_state == ST_CHK);

    rx_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk     (bounderClock),
        .i_rst     (reset),
        .i_clear   (rx_ready),
        .i_enable  (w_in_packet),
        .o_expired (w_expired)
    );

    always_ff @(posedge bounderClock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_frame_error = 1'b0;
        w_overrun     = 1'b0;
        w_load_hdr    = 1'b0;
        w_load_arg    = 1'b0;
        w_load_cmd    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_ready && (rx_data == SYNC_BYTE)) begin
                    w_next_state = ST_HDR;
                end
            end
            ST_HDR: begin
                if (rx_ready) begin
                    if (rx_data[HDR_PAD_MSB:HDR_PAD_LSB] == '0) begin
                        w_load_hdr   = 1'b1;
                        w_next_state = ST_ARG;
                    end else if (rx_data != SYNC_BYTE) begin
                        w_frame_error = 1'b1;
                        w_next_state  = ST_IDLE;
                    end
                end else if (w_expired) begin
                    w_frame_error = 1'b1;
                    w_next_state  = ST_IDLE;
                end
            end
            ST_ARG: begin
                if (rx_ready) begin
                    w_load_arg   = 1'b1;
                    w_next_state = ST_CHK;
                end else if (w_expired) begin
                    w_frame_error = 1'b1;
                    w_next_state  = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (rx_ready) begin
                    if (rx_data == (r_hdr ^ r_arg)) begin
                        w_load_cmd   = 1'b1;
                        w_next_state = ST_HOLD;
                    end else begin
                        w_frame_error = 1'b1;
                        w_next_state  = ST_IDLE;
                    end
                end else if (w_expired) begin
                    w_frame_error = 1'b1;
                    w_next_state  = ST_IDLE;
                end
            end
            ST_HOLD: begin
                w_overrun = rx_ready;
                if (cmd_accept) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge bounderClock or posedge reset) begin
        if (reset) begin
            r_hdr         <= '0;
            r_arg         <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_player  <= 1'b0;
            r_cmd_code    <= '0;
            r_cmd_arg     <= '0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
            r_err_count   <= '0;
        end else begin
            if (w_load_hdr) begin
                r_hdr <= rx_data;
            end
            if (w_load_arg) begin
                r_arg <= rx_data;
            end
            if (w_load_cmd) begin
                r_cmd_player <= r_hdr[HDR_PLAYER_BIT];
                r_cmd_code   <= r_hdr[HDR_CODE_MSB:HDR_CODE_LSB];
                r_cmd_arg    <= r_arg;
            end
            r_cmd_valid   <= (w_next_state == ST_HOLD);
            r_busy        <= (w_next_state != ST_IDLE);
            r_frame_error <= w_frame_error;
            r_overrun     <= w_overrun;
            // Clear takes priority over a same-cycle error increment.
            if (clear_err) begin
                r_err_count <= '0;
            end else if ((w_frame_error || w_overrun) && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign cmd_valid   = r_cmd_valid;
    assign cmd_player  = r_cmd_player;
    assign cmd_code    = r_cmd_code;
    assign cmd_arg     = r_cmd_arg;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;
    assign busy        = r_busy;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_pong_rx_controller.sv
// Directed bench for pong_rx_controller: packet decode, checksum/header errors,
// timeout boundary, resync, overrun/saturation and asynchronous reset.
module tb_pong_rx_controller;

    localparam int unsigned T = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_ready = 1'b0;
    logic       cmd_accept = 1'b0;
    logic       clear_err = 1'b0;
    logic       cmd_valid;
    logic       cmd_player;
    logic [1:0] cmd_code;
    logic [7:0] cmd_arg;
    logic       frame_error;
    logic       overrun;
    logic       busy;
    logic [7:0] err_count;

    int passed = 0;
    int total  = 0;

    pong_rx_controller #(
        .TIMEOUT_CYCLES(T),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .bounderClock (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .cmd_accept   (cmd_accept),
        .clear_err    (clear_err),
        .cmd_valid    (cmd_valid),
        .cmd_player   (cmd_player),
        .cmd_code     (cmd_code),
        .cmd_arg      (cmd_arg),
        .frame_error  (frame_error),
        .overrun      (overrun),
        .busy         (busy),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic accept();
        cmd_accept = 1'b1;
        tick();
        cmd_accept = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        total++; if (cmd_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", cmd_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if ({cmd_player, cmd_code, cmd_arg} !== 11'd0) $display("FAIL reset_cmd: got %h want 0", {cmd_player, cmd_code, cmd_arg}); else passed++;
        total++; if (err_count !== 8'd0) $display("FAIL reset_err: got %0d want 0", err_count); else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_good_packet();
        int fe = 0;
        send_byte(8'hA5);
        send_byte(8'h81);
        send_byte(8'h40);
        total++; if (busy !== 1'b1 || cmd_valid !== 1'b0) $display("FAIL good_busy: got busy=%b valid=%b want 1/0", busy, cmd_valid); else passed++;
        send_byte(8'hC1);
        total++; if (cmd_valid !== 1'b1) $display("FAIL good_valid: got %b want 1", cmd_valid); else passed++;
        total++; if (cmd_player !== 1'b1 || cmd_code !== 2'd1 || cmd_arg !== 8'h40)
            $display("FAIL good_fields: got p=%b c=%0d a=%h want 1/1/40", cmd_player, cmd_code, cmd_arg); else passed++;
        for (int i = 0; i < int'(T) + 4; i++) begin
            tick();
            if (frame_error) fe++;
        end
        total++; if (cmd_valid !== 1'b1 || fe != 0) $display("FAIL good_hold: got valid=%b errs=%0d want 1/0", cmd_valid, fe); else passed++;
        accept();
        total++; if (cmd_valid !== 1'b0 || busy !== 1'b0) $display("FAIL good_drop: got valid=%b busy=%b want 0/0", cmd_valid, busy); else passed++;
        total++; if (cmd_arg !== 8'h40 || cmd_code !== 2'd1) $display("FAIL good_keep: got a=%h c=%0d want 40/1", cmd_arg, cmd_code); else passed++;
        accept();
        total++; if (busy !== 1'b0 || cmd_valid !== 1'b0) $display("FAIL idle_accept: got busy=%b valid=%b want 0/0", busy, cmd_valid); else passed++;
    endtask

    task automatic test_bad_checksum();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h13);
        total++; if (frame_error !== 1'b1 || err_count !== 8'd1) $display("FAIL chk_err: got fe=%b cnt=%0d want 1/1", frame_error, err_count); else passed++;
        total++; if (cmd_valid !== 1'b0 || busy !== 1'b0) $display("FAIL chk_state: got valid=%b busy=%b want 0/0", cmd_valid, busy); else passed++;
        total++; if (cmd_code !== 2'd1 || cmd_arg !== 8'h40) $display("FAIL chk_keep: got c=%0d a=%h want 1/40", cmd_code, cmd_arg); else passed++;
        tick();
        total++; if (frame_error !== 1'b0) $display("FAIL chk_pulse: got %b want 0", frame_error); else passed++;
        send_byte(8'hA5);
        send_byte(8'h44);
        total++; if (frame_error !== 1'b1 || err_count !== 8'd2 || busy !== 1'b0) $display("FAIL hdr_err: got fe=%b cnt=%0d busy=%b want 1/2/0", frame_error, err_count, busy); else passed++;
        tick();
    endtask

    task automatic test_timeout();
        int fe = 0;
        send_byte(8'hA5);
        for (int i = 0; i < int'(T) - 1; i++) begin
            tick();
            if (frame_error) fe++;
        end
        total++; if (fe != 0 || busy !== 1'b1) $display("FAIL to_early: got errs=%0d busy=%b want 0/1", fe, busy); else passed++;
        tick();
        total++; if (frame_error !== 1'b1 || busy !== 1'b0 || err_count !== 8'd3) $display("FAIL to_fire: got fe=%b busy=%b cnt=%0d want 1/0/3", frame_error, busy, err_count); else passed++;
        tick();
        send_byte(8'hA5);
        repeat (T - 1) tick();
        send_byte(8'h81);
        total++; if (frame_error !== 1'b0 || busy !== 1'b1) $display("FAIL to_edge_byte: got fe=%b busy=%b want 0/1", frame_error, busy); else passed++;
        send_byte(8'h40);
        send_byte(8'hC1);
        total++; if (cmd_valid !== 1'b1 || err_count !== 8'd3) $display("FAIL to_edge_pkt: got valid=%b cnt=%0d want 1/3", cmd_valid, err_count); else passed++;
        accept();
    endtask

    task automatic test_resync();
        send_byte(8'hA5);
        send_byte(8'hA5);
        total++; if (frame_error !== 1'b0 || busy !== 1'b1) $display("FAIL resync_hdr: got fe=%b busy=%b want 0/1", frame_error, busy); else passed++;
        send_byte(8'h03);
        send_byte(8'h20);
        send_byte(8'h23);
        total++; if (cmd_valid !== 1'b1 || cmd_player !== 1'b0 || cmd_code !== 2'd3 || cmd_arg !== 8'h20)
            $display("FAIL resync_cmd: got v=%b p=%b c=%0d a=%h want 1/0/3/20", cmd_valid, cmd_player, cmd_code, cmd_arg); else passed++;
        total++; if (err_count !== 8'd3) $display("FAIL resync_cnt: got %0d want 3", err_count); else passed++;
        accept();
    endtask

    task automatic test_overrun();
        send_byte(8'hA5);
        send_byte(8'h82);
        send_byte(8'h33);
        send_byte(8'hB1);
        send_byte(8'hA5);
        total++; if (overrun !== 1'b1 || err_count !== 8'd4 || cmd_valid !== 1'b1) $display("FAIL ovr_pulse: got ovr=%b cnt=%0d valid=%b want 1/4/1", overrun, err_count, cmd_valid); else passed++;
        tick();
        total++; if (overrun !== 1'b0) $display("FAIL ovr_single: got %b want 0", overrun); else passed++;
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        total++; if (err_count !== 8'd255 || cmd_valid !== 1'b1) $display("FAIL ovr_sat: got cnt=%0d valid=%b want 255/1", err_count, cmd_valid); else passed++;
        total++; if (cmd_code !== 2'd2 || cmd_arg !== 8'h33 || cmd_player !== 1'b1) $display("FAIL ovr_stable: got p=%b c=%0d a=%h want 1/2/33", cmd_player, cmd_code, cmd_arg); else passed++;
        clear_err = 1'b1;
        send_byte(8'h11);
        clear_err = 1'b0;
        total++; if (err_count !== 8'd0 || overrun !== 1'b1) $display("FAIL ovr_clear: got cnt=%0d ovr=%b want 0/1", err_count, overrun); else passed++;
        accept();
        send_byte(8'h81);
        total++; if (busy !== 1'b0) $display("FAIL ovr_nosync: got busy=%b want 0", busy); else passed++;
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5);
        send_byte(8'h81);
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || frame_error !== 1'b0) $display("FAIL rst_mid: got busy=%b fe=%b want 0/0", busy, frame_error); else passed++;
        tick();
        reset = 1'b0;
        tick();
        send_byte(8'hA5);
        send_byte(8'h81);
        send_byte(8'h40);
        send_byte(8'hC1);
        reset = 1'b1;
        #1;
        total++; if (cmd_valid !== 1'b0 || {cmd_player, cmd_code, cmd_arg} !== 11'd0) $display("FAIL rst_hold: got v=%b cmd=%h want 0/0", cmd_valid, {cmd_player, cmd_code, cmd_arg}); else passed++;
        tick();
        reset = 1'b0;
        tick();
        send_byte(8'hA5);
        send_byte(8'h82);
        send_byte(8'h33);
        send_byte(8'hB1);
        total++; if (cmd_valid !== 1'b1 || cmd_player !== 1'b1 || cmd_code !== 2'd2 || cmd_arg !== 8'h33 || err_count !== 8'd0)
            $display("FAIL rst_after: got v=%b p=%b c=%0d a=%h cnt=%0d want 1/1/2/33/0", cmd_valid, cmd_player, cmd_code, cmd_arg, err_count); else passed++;
        accept();
    endtask

    task automatic test_back_to_back();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h07);
        send_byte(8'h06);
        total++; if (cmd_valid !== 1'b1 || cmd_code !== 2'd1 || cmd_arg !== 8'h07) $display("FAIL b2b_first: got v=%b c=%0d a=%h want 1/1/07", cmd_valid, cmd_code, cmd_arg); else passed++;
        accept();
        send_byte(8'hA5);
        total++; if (busy !== 1'b1) $display("FAIL b2b_sync: got busy=%b want 1", busy); else passed++;
        send_byte(8'h00);
        send_byte(8'h55);
        send_byte(8'h55);
        total++; if (cmd_valid !== 1'b1 || cmd_player !== 1'b0 || cmd_code !== 2'd0 || cmd_arg !== 8'h55)
            $display("FAIL b2b_second: got v=%b p=%b c=%0d a=%h want 1/0/0/55", cmd_valid, cmd_player, cmd_code, cmd_arg); else passed++;
        accept();
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_checksum();
        test_timeout();
        test_resync();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pong_rx_controller.md
# pong_rx_controller

Sequences the serial byte receiver into validated Pong control commands. Consumes the receiver's one-cycle byte-ready pulse and parsed byte, frames 4-byte packets (sync, header, argument, checksum), enforces an inter-byte timeout, and presents each good command to game logic through a valid/accept handshake. Errors are flagged as pulses and counted.

## Interface
- TIMEOUT_CYCLES, default 2000: max bounderClock cycles allowed between bytes inside a packet (≥ 2).
- SYNC_BYTE, default 8'hA5: packet start marker.
- bounderClock  in  1  bit-rate clock shared with the receiver.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- rx_data  in  8  byte from receiver; sampled only when rx_ready = 1.
- rx_ready  in  1  one-cycle pulse, one byte per pulse.
- cmd_accept  in  1  game logic consumes the held command.
- clear_err  in  1  synchronous clear of err_count.
- cmd_valid  out  1  command held and stable until accepted.
- cmd_player  out  1  0 = left paddle, 1 = right paddle.
- cmd_code  out  2  0 STOP, 1 UP, 2 DOWN, 3 SERVE.
- cmd_arg  out  8  speed/argument byte.
- frame_error  out  1  one-cycle pulse: timeout, bad header or bad checksum.
- overrun  out  1  one-cycle pulse: byte received while a command is held.
- busy  out  1  high in HDR, ARG, CHK, HOLD.
- err_count  out  8  saturating count of frame_error and overrun pulses.

## Operation
- States: IDLE, HDR, ARG, CHK, HOLD. Reset → IDLE; all outputs 0, cmd_* 0, err_count 0.
- IDLE: on rx_ready with rx_data == SYNC_BYTE → HDR; other bytes ignored silently.
- HDR: header = {player, 5'b0, code}. Valid (bits 6:2 == 0) → latch player/code, → ARG. rx_data == SYNC_BYTE → stay HDR, timer restarts, no error (resync). Other invalid → frame_error, → IDLE.
- ARG: latch arg byte, → CHK.
- CHK: byte == header XOR arg → load cmd_* outputs, → HOLD. Mismatch → frame_error, → IDLE; cmd_* unchanged.
- HOLD: cmd_valid = 1; cmd_* stable. cmd_accept sampled high → IDLE. rx_ready in HOLD → byte dropped, overrun pulse, stay HOLD (a dropped SYNC_BYTE does not start a packet).
- Timeout: counter clears on entering HDR and on every rx_ready in HDR/ARG/CHK; increments each other cycle there. When it equals TIMEOUT_CYCLES−1 with no rx_ready → frame_error, → IDLE. rx_ready in the same cycle wins (no timeout). No timeout in IDLE or HOLD.
- err_count: +1 per frame_error or overrun pulse, saturates at 255. clear_err wins over a simultaneous increment.
- Output cmd_* keep last accepted values after cmd_valid drops.

## Timing
- All outputs registered. State changes on the bounderClock edge at which rx_ready is sampled.
- cmd_valid rises the cycle after the checksum byte's rx_ready; latency 1 cycle.
- cmd_valid falls the cycle after cmd_accept is sampled high; cmd_accept while cmd_valid = 0 is ignored.
- frame_error/overrun high exactly one cycle, the cycle after the causing edge; err_count updates same edge.
- Minimum packet spacing: next SYNC_BYTE accepted the cycle after return to IDLE.
- reset asserted mid-packet or in HOLD: immediate clear, no pulses, held command lost.

## Structure
- Shared package pong_pkg: SYNC_BYTE default, command code constants (CMD_STOP/UP/DOWN/SERVE), state encoding, header field positions.
- One sub-module: rx_timeout_timer (clear, enable, expired output; width $clog2(TIMEOUT_CYCLES)). FSM, field latches and error counter stay in the top.

## Test plan
- Bytes A5,81,40,C1 with cmd_accept held low → cmd_valid=1, player=1, code=1, arg=0x40 one cycle after 4th byte; stays until cmd_accept, drops next cycle.
- A5,02,10,13 (bad checksum, expect 12) → frame_error one pulse, err_count=1, cmd_valid stays 0, FSM back to IDLE.
- A5 then no byte for TIMEOUT_CYCLES cycles → frame_error after exactly TIMEOUT_CYCLES−1 idle cycles; byte arriving on that cycle instead → no error.
- A5,A5,03,20,23 → resync in HDR, no error, command code 3 arg 0x20 delivered.
- Command held, send A5 → overrun pulse, err_count increments, state stays HOLD; then 256 more errors → err_count saturates at 255; clear_err → 0.
- Assert reset after A5,81 → all outputs 0 immediately; next full packet decodes normally.
